// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, instruction field
// positions, FSM state encoding and field-extraction helpers.
package datapath_sequencer_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_LSB  = 12;
  localparam int DEST_LSB = 9;
  localparam int SRC_LSB  = 6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_FETCH_IMM = 2'd2,
    ST_EXEC      = 2'd3
  } seq_state_t;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: 4];
  endfunction

  function automatic logic [2:0] instr_dest(input logic [INSTR_W-1:0] w);
    return w[DEST_LSB +: 3];
  endfunction

  function automatic logic [2:0] instr_src(input logic [INSTR_W-1:0] w);
    return w[SRC_LSB +: 3];
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction-memory handshake and datapath control bundle.
interface datapath_sequencer_if
  import datapath_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         dp_opcode;
  logic [2:0]         dp_src_reg;
  logic [2:0]         dp_dest_reg;
  logic [INSTR_W-1:0] dp_immediate;
  logic [INSTR_W-1:0] dp_result;

  modport master (
    output imem_req, imem_addr, dp_opcode, dp_src_reg, dp_dest_reg, dp_immediate,
    input  imem_ack, imem_rdata, dp_result
  );

  modport slave (
    input  imem_req, imem_addr, dp_opcode, dp_src_reg, dp_dest_reg, dp_immediate,
    output imem_ack, imem_rdata, dp_result
  );
endinterface

// File: rtl/datapath_sequencer_instr_decode.sv
// Opcode classifier used while the fetch handshake completes.
module instr_decode
  import datapath_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       needs_imm_o,
  output logic       alu_op_o,
  output logic       nop_o,
  output logic       halt_o,
  output logic       illegal_o
);

  // One-hot classification; anything not listed is illegal.
  always_comb begin
    needs_imm_o = 1'b0;
    alu_op_o    = 1'b0;
    nop_o       = 1'b0;
    halt_o      = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OP_NOP:                 nop_o       = 1'b1;
      OP_LOAD:                needs_imm_o = 1'b1;
      OP_MOV, OP_ADD, OP_XOR: alu_op_o    = 1'b1;
      OP_HALT:                halt_o      = 1'b1;
      default:                illegal_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer: fetches words from instruction memory, decodes them
// and drives one datapath write per executed op.
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_FETCH     | requesting the instruction word at pc
// ST_FETCH_IMM | requesting the LOAD immediate word at pc
// ST_EXEC      | single cycle presenting controls to the datapath
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  datapath_sequencer_if.master bus,
  output logic [INSTR_W-1:0]   last_result,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          instr_count
);

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [3:0]         op_q, op_d;
  logic [2:0]         dest_q, dest_d;
  logic [2:0]         src_q, src_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic [INSTR_W-1:0] last_result_q, last_result_d;
  logic [15:0]        count_q, count_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic needs_imm, alu_op, is_nop, is_halt, is_illegal;

  instr_decode u_decode (
    .opcode_i    (instr_opcode(bus.imem_rdata)),
    .needs_imm_o (needs_imm),
    .alu_op_o    (alu_op),
    .nop_o       (is_nop),
    .halt_o      (is_halt),
    .illegal_o   (is_illegal)
  );

  // Next-state and register-update logic; registers hold unless a branch below changes them.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    op_d          = op_q;
    dest_d        = dest_q;
    src_d         = src_q;
    imm_d         = imm_q;
    last_result_d = last_result_q;
    count_d       = count_q;
    err_d         = err_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          err_d   = 1'b0;
          count_d = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          op_d   = instr_opcode(bus.imem_rdata);
          dest_d = instr_dest(bus.imem_rdata);
          src_d  = instr_src(bus.imem_rdata);
          // Non-LOAD ops present a zero immediate rather than a stale one.
          imm_d  = '0;
          pc_d   = pc_q + 1'b1;
          if (needs_imm) begin
            state_d = ST_FETCH_IMM;
          end else if (alu_op) begin
            state_d = ST_EXEC;
          end else if (is_nop) begin
            count_d = count_q + 16'd1;
          end else if (is_halt) begin
            count_d = count_q + 16'd1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (is_illegal) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FETCH_IMM: begin
        if (bus.imem_ack) begin
          imm_d   = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        last_result_d = bus.dp_result;
        count_d       = count_q + 16'd1;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      op_q          <= '0;
      dest_q        <= '0;
      src_q         <= '0;
      imm_q         <= '0;
      last_result_q <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      op_q          <= op_d;
      dest_q        <= dest_d;
      src_q         <= src_d;
      imm_q         <= imm_d;
      last_result_q <= last_result_d;
      count_q       <= count_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  // Outputs come only from the state register and latched fields, never from imem inputs.
  assign bus.imem_req     = (state_q == ST_FETCH) || (state_q == ST_FETCH_IMM);
  assign bus.imem_addr    = pc_q;
  assign bus.dp_opcode    = (state_q == ST_EXEC) ? op_q   : OP_NOP;
  assign bus.dp_src_reg   = (state_q == ST_EXEC) ? src_q  : 3'd0;
  assign bus.dp_dest_reg  = (state_q == ST_EXEC) ? dest_q : 3'd0;
  assign bus.dp_immediate = (state_q == ST_EXEC) ? imm_q  : '0;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign err              = err_q;
  assign last_result      = last_result_q;
  assign instr_count      = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: instruction memory with programmable ack delay, a small
// register-file datapath, and hand-computed expectations.
module tb_datapath_sequencer;
  import datapath_sequencer_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [15:0]   last_result;
  logic [15:0]   instr_count;
  logic          busy, done, err;

  datapath_sequencer_if #(.ADDR_W(AW)) bus ();

  datapath_sequencer #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .bus         (bus),
    .last_result (last_result),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]   mem [256];
  logic [15:0]   regs [8];
  logic [AW-1:0] fetch_log [128];
  int            ack_delay = 0;
  int            busy_cycles = 0, done_cnt = 0, dp_writes = 0, addr_viol = 0, nfetch = 0;
  int            wait_cnt = 0;
  logic [AW-1:0] held_addr;
  logic [15:0]   res;

  int b_busy, b_done, b_dp, b_viol, b_fetch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b_busy  = busy_cycles;
    b_done  = done_cnt;
    b_dp    = dp_writes;
    b_viol  = addr_viol;
    b_fetch = nfetch;
  endtask

  task automatic start_pulse(input logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic run_prog(input logic [AW-1:0] a, input int dly, input int budget);
    ack_delay = dly;
    snap();
    start_pulse(a);
    wait_done(budget);
  endtask

  // Environment: activity monitor, register-file datapath, instruction memory responder.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dp_result  = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (bus.dp_opcode != OP_NOP) begin
        dp_writes++;
        case (bus.dp_opcode)
          OP_LOAD: res = bus.dp_immediate;
          OP_MOV:  res = regs[bus.dp_src_reg];
          OP_ADD:  res = regs[bus.dp_dest_reg] + regs[bus.dp_src_reg];
          OP_XOR:  res = regs[bus.dp_dest_reg] ^ regs[bus.dp_src_reg];
          default: res = 16'hDEAD;
        endcase
        regs[bus.dp_dest_reg] = res;
        bus.dp_result = res;
      end else begin
        bus.dp_result = '0;
      end
      if (bus.imem_req && !reset) begin
        if (wait_cnt == 0) held_addr = bus.imem_addr;
        else if (bus.imem_addr !== held_addr) addr_viol++;
        if (wait_cnt >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          fetch_log[nfetch % 128] = bus.imem_addr;
          nfetch++;
          wait_cnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    bit found;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    // LOAD r1,0x1234 ; LOAD r2,0x00FF ; ADD r1+=r2 ; HALT
    mem[8'h10] = 16'h1200; mem[8'h11] = 16'h1234;
    mem[8'h12] = 16'h1400; mem[8'h13] = 16'h00FF;
    mem[8'h14] = 16'h3280; mem[8'h15] = 16'hF000;
    // LOAD r1,0x00A5 ; NOP ; MOV r4<-r1 ; HALT  (and an illegal word at 0x80)
    mem[8'h40] = 16'h1200; mem[8'h41] = 16'h00A5;
    mem[8'h42] = 16'h0000; mem[8'h43] = 16'h2840;
    mem[8'h44] = 16'hF000; mem[8'h80] = 16'h9000;

    tick(); tick();
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_req",     32'(bus.imem_req),  32'd0);
    chk("rst_addr",    32'(bus.imem_addr), 32'd0);
    chk("rst_count",   32'(instr_count),   32'd0);
    chk("rst_result",  32'(last_result),   32'd0);
    chk("rst_done",    32'(done),          32'd0);
    chk("rst_err",     32'(err),           32'd0);
    chk("rst_dp_op",   32'(bus.dp_opcode), 32'd0);
    reset = 1'b0;
    tick();

    // Zero-wait program.
    run_prog(8'h10, 0, 60);
    chk("p0_dp_writes", dp_writes - b_dp,      32'd3);
    chk("p0_result",    32'(last_result),      32'h1333);
    chk("p0_count",     32'(instr_count),      32'd4);
    chk("p0_done_cnt",  done_cnt - b_done,     32'd1);
    chk("p0_err",       32'(err),              32'd0);
    chk("p0_cycles",    busy_cycles - b_busy,  32'd9);
    chk("p0_r1",        32'(regs[1]),          32'h1333);

    // Same program, ack after 3 wait cycles per request.
    run_prog(8'h10, 3, 120);
    chk("p3_addr_stable", addr_viol - b_viol,   32'd0);
    chk("p3_result",      32'(last_result),     32'h1333);
    chk("p3_count",       32'(instr_count),     32'd4);
    chk("p3_cycles",      busy_cycles - b_busy, 32'd27);
    chk("p3_dp_writes",   dp_writes - b_dp,     32'd3);
    chk("p3_done_cnt",    done_cnt - b_done,    32'd1);

    // Illegal opcode at address 2 after two NOPs.
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0000; mem[8'h02] = 16'h9000;
    run_prog(8'h00, 0, 40);
    chk("ill_err",       32'(err),             32'd1);
    chk("ill_done_cnt",  done_cnt - b_done,    32'd1);
    chk("ill_busy",      32'(busy),            32'd0);
    chk("ill_dp_writes", dp_writes - b_dp,     32'd0);
    chk("ill_count",     32'(instr_count),     32'd2);
    chk("ill_cycles",    busy_cycles - b_busy, 32'd3);

    // pc wrap between opcode and immediate word.
    mem[8'hFF] = 16'h1600; mem[8'h00] = 16'hBEEF; mem[8'h01] = 16'hF000;
    run_prog(8'hFF, 0, 40);
    chk("wrap_first_addr", 32'(fetch_log[b_fetch % 128]),       32'h00FF);
    chk("wrap_imm_addr",   32'(fetch_log[(b_fetch + 1) % 128]), 32'h0000);
    chk("wrap_result",     32'(last_result),                    32'hBEEF);
    chk("wrap_r3",         32'(regs[3]),                        32'hBEEF);
    chk("wrap_count",      32'(instr_count),                    32'd2);
    chk("wrap_err_clr",    32'(err),                            32'd0);

    // start while busy must be ignored.
    ack_delay = 2;
    snap();
    start_pulse(8'h40);
    tick(); tick();
    chk("sb_busy_before", 32'(busy), 32'd1);
    start_pulse(8'h80);
    wait_done(120);
    chk("sb_count",     32'(instr_count),                     32'd4);
    chk("sb_result",    32'(last_result),                     32'h00A5);
    chk("sb_r4",        32'(regs[4]),                         32'h00A5);
    chk("sb_err",       32'(err),                             32'd0);
    chk("sb_nfetch",    nfetch - b_fetch,                     32'd5);
    chk("sb_last_addr", 32'(fetch_log[(nfetch - 1) % 128]),   32'h0044);

    // Reset while the immediate fetch is waiting for ack.
    ack_delay = 3;
    snap();
    start_pulse(8'h10);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 8'h11) found = 1'b1;
      else tick();
    end
    chk("mr_reach_imm", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy",   32'(busy),             32'd0);
    chk("mr_req",    32'(bus.imem_req),     32'd0);
    chk("mr_addr",   32'(bus.imem_addr),    32'd0);
    chk("mr_result", 32'(last_result),      32'd0);
    chk("mr_count",  32'(instr_count),      32'd0);
    chk("mr_err",    32'(err),              32'd0);
    chk("mr_done",   32'(done),             32'd0);
    chk("mr_dp_op",  32'(bus.dp_opcode),    32'd0);
    chk("mr_dp_imm", 32'(bus.dp_immediate), 32'd0);
    tick();

    run_prog(8'h10, 0, 60);
    chk("post_result", 32'(last_result), 32'h1333);
    chk("post_count",  32'(instr_count), 32'd4);
    chk("post_err",    32'(err),         32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
